// File: rtl/dmem_master.sv
// ---------------------------------------------------------------------------
// dmem_master
//
// Converts single CPU load/store requests (LW/LB/LBU/LH/LHU/SW/SB/SH) into
// word-wide accesses on a simple synchronous data memory. Byte and halfword
// stores are done as read-modify-write. Misaligned word/halfword accesses
// finish at once with err set and never touch the memory.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   req              request pulse, only looked at while idle
//   op[2:0]          0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 SW, 6 SB, 7 SH
//   addr[31:0]       byte address (only bits [11:0] are used, 4 KiB wrap)
//   wdata[31:0]      store data, right-justified for SB/SH
//   busy             high while an access is in flight
//   done             one-cycle completion pulse
//   err              misalignment flag, valid with done
//   rdata[31:0]      extended load result, held until the next load
//   DM_ena           DM_r | DM_w
//   DM_r             read strobe, DM_rdata valid in the same cycle
//   DM_w             write strobe, committed at the next rising edge
//   DM_addr[31:0]    word index into the memory
//   DM_wdata[31:0]   word to write
//   DM_rdata[31:0]   word read from the memory
// ---------------------------------------------------------------------------
module dmem_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        DM_ena,
    output logic        DM_r,
    output logic        DM_w,
    output logic [31:0] DM_addr,
    output logic [31:0] DM_wdata,
    input  logic [31:0] DM_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q,    op_d;
    logic [11:0] addr_q,  addr_d;
    logic [31:0] wd_q,    wd_d;
    logic [31:0] word_q,  word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic        rd_raw,  wr_raw;

    // Upper address bits are deliberately dropped: the memory wraps at 4 KiB.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:12];

    function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
        case (o)
            OP_LW, OP_SW:         return a != 2'b00;
            OP_LH, OP_LHU, OP_SH: return a[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [2:0] o);
        return o inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
    endfunction

    // Little-endian lane extraction with sign/zero extension.
    function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (o)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'b0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the word read back in RD.
    function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] a,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (o == OP_SB)      r[{a, 3'b000} +: 8]     = d[7:0];
        else if (o == OP_SH) r[{a[1], 4'b0000} +: 16] = d[15:0];
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rd_raw  = 1'b0;
        wr_raw  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d   = op;
                    addr_d = addr[11:0];
                    wd_d   = wdata;
                    if (is_misaligned(op, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (op == OP_SW) ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                rd_raw = 1'b1;
                word_d = DM_rdata;
                if (is_load(op_q)) begin
                    rdata_d = extract(op_q, addr_q[1:0], DM_rdata);
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                wr_raw  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of the others.
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes and status are gated by rst so an in-flight write cannot
    // commit on the reset edge.
    assign DM_r     = rd_raw & ~rst;
    assign DM_w     = wr_raw & ~rst;
    assign DM_ena   = DM_r | DM_w;
    assign busy     = (state_q != S_IDLE) & ~rst;
    assign done     = (state_q == S_DONE) & ~rst;
    assign err      = done & err_q;
    assign rdata    = rdata_q;
    assign DM_addr  = {22'b0, addr_q[11:2]};
    assign DM_wdata = (op_q == OP_SW) ? wd_q : merge(op_q, addr_q[1:0], word_q, wd_q);

endmodule

// File: tb/tb_dmem_master.sv
// ---------------------------------------------------------------------------
// tb_dmem_master
//
// Directed bench for dmem_master with a 1024-word behavioural data memory.
// A table of single accesses is applied in order; each one checks latency,
// err, rdata (loads and misaligned accesses), the written word and its
// index (stores), and the number of read/write strobe cycles. Hand-written
// sequences cover reset during WR, reset vs. req, and back-to-back requests.
// ---------------------------------------------------------------------------
module tb_dmem_master;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        DM_ena, DM_r, DM_w;
    logic [31:0] DM_addr, DM_wdata, DM_rdata;

    logic [31:0] mem [0:1023];
    logic        dual_seen = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_ww;
    } vec_t;

    vec_t vecs [21];

    dmem_master dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .DM_ena   (DM_ena),
        .DM_r     (DM_r),
        .DM_w     (DM_w),
        .DM_addr  (DM_addr),
        .DM_wdata (DM_wdata),
        .DM_rdata (DM_rdata)
    );

    always #5 clk = ~clk;

    assign DM_rdata = DM_r ? mem[DM_addr[9:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (DM_w) mem[DM_addr[9:0]] <= DM_wdata;
    end

    always @(negedge clk) begin
        if (DM_r && DM_w) dual_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_store(input logic [2:0] o);
        return o inside {OP_SW, OP_SB, OP_SH};
    endfunction

    // Issue one access from IDLE and check it through to done, then wait
    // one more cycle so the DUT is back in IDLE.
    task automatic run_vec(input string tag, input vec_t v);
        int          lat;
        int          nr, nw;
        logic        got;
        logic        err_s;
        logic [31:0] rd_s, ww_s, wa_s;
        int          exp_nr, exp_nw;
        lat = 0; nr = 0; nw = 0; got = 1'b0;
        err_s = 1'b0; rd_s = '0; ww_s = '0; wa_s = '0;
        @(negedge clk);
        req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) req = 1'b0;
            if (DM_r) nr++;
            if (DM_w) begin
                nw++;
                ww_s = DM_wdata;
                wa_s = DM_addr;
            end
            if (done) begin
                got   = 1'b1;
                lat   = c;
                err_s = err;
                rd_s  = rdata;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: no done within 8 cycles", tag);
            return;
        end
        if (v.exp_err) begin
            exp_nr = 0; exp_nw = 0;
        end else begin
            exp_nr = (v.op == OP_SW) ? 0 : 1;
            exp_nw = is_store(v.op) ? 1 : 0;
        end
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " err"}, {31'b0, err_s}, {31'b0, v.exp_err});
        check({tag, " DM_r cycles"}, nr, exp_nr);
        check({tag, " DM_w cycles"}, nw, exp_nw);
        if (!is_store(v.op) || v.exp_err) check({tag, " rdata"}, rd_s, v.exp_rd);
        if (is_store(v.op) && !v.exp_err) begin
            check({tag, " DM_wdata"}, ww_s, v.exp_ww);
            check({tag, " DM_addr"}, wa_s, {22'b0, v.addr[11:2]});
        end
        @(posedge clk);
        #1;
        check({tag, " busy after done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int   n_done, n_idle;
        logic prev_idle, prev_done, run_bad, seen;
        vec_t v;

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        //                op      addr           wdata          exp_rd         err  lat exp_ww
        vecs[0]  = '{OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 32'hDEAD_BEEF};
        vecs[1]  = '{OP_LW,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 32'h0};
        vecs[2]  = '{OP_SW,  32'h0000_0010, 32'h1122_3344, 32'h0,         1'b0, 2, 32'h1122_3344};
        vecs[3]  = '{OP_SB,  32'h0000_0011, 32'h0000_00AB, 32'h0,         1'b0, 3, 32'h1122_AB44};
        vecs[4]  = '{OP_LW,  32'h0000_0010, 32'h0,         32'h1122_AB44, 1'b0, 2, 32'h0};
        vecs[5]  = '{OP_SW,  32'h0000_0000, 32'h8000_FF7F, 32'h0,         1'b0, 2, 32'h8000_FF7F};
        vecs[6]  = '{OP_LB,  32'h0000_0000, 32'h0,         32'h0000_007F, 1'b0, 2, 32'h0};
        vecs[7]  = '{OP_LB,  32'h0000_0001, 32'h0,         32'hFFFF_FFFF, 1'b0, 2, 32'h0};
        vecs[8]  = '{OP_LBU, 32'h0000_0001, 32'h0,         32'h0000_00FF, 1'b0, 2, 32'h0};
        vecs[9]  = '{OP_LH,  32'h0000_0002, 32'h0,         32'hFFFF_8000, 1'b0, 2, 32'h0};
        vecs[10] = '{OP_LHU, 32'h0000_0002, 32'h0,         32'h0000_8000, 1'b0, 2, 32'h0};
        vecs[11] = '{OP_LW,  32'h0000_0013, 32'h0,         32'h0000_8000, 1'b1, 1, 32'h0};
        vecs[12] = '{OP_SH,  32'h0000_0005, 32'h0000_1234, 32'h0000_8000, 1'b1, 1, 32'h0};
        vecs[13] = '{OP_SH,  32'h0000_1002, 32'h1234_CAFE, 32'h0,         1'b0, 3, 32'hCAFE_FF7F};
        vecs[14] = '{OP_LW,  32'h0000_0000, 32'h0,         32'hCAFE_FF7F, 1'b0, 2, 32'h0};
        vecs[15] = '{OP_SB,  32'h0000_0003, 32'h0000_0080, 32'h0,         1'b0, 3, 32'h80FE_FF7F};
        vecs[16] = '{OP_LH,  32'h0000_0002, 32'h0,         32'hFFFF_80FE, 1'b0, 2, 32'h0};
        vecs[17] = '{OP_LBU, 32'h0000_0003, 32'h0,         32'h0000_0080, 1'b0, 2, 32'h0};
        vecs[18] = '{OP_LH,  32'h0000_0003, 32'h0,         32'h0000_0080, 1'b1, 1, 32'h0};
        vecs[19] = '{OP_LB,  32'h7FFF_F003, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 32'h0};
        vecs[20] = '{OP_SW,  32'h0000_0002, 32'h5555_5555, 32'hFFFF_FF80, 1'b1, 1, 32'h0};

        // Reset state, with rst still asserted and then released.
        rst = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'b0, busy},   32'd0);
        check("reset done",   {31'b0, done},   32'd0);
        check("reset err",    {31'b0, err},    32'd0);
        check("reset DM_ena", {31'b0, DM_ena}, 32'd0);
        check("reset rdata",  rdata,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle busy", {31'b0, busy}, 32'd0);
        check("idle DM_r", {31'b0, DM_r}, 32'd0);

        for (int i = 0; i < 21; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted during the WR cycle of an SB: nothing is written.
        @(negedge clk);
        req = 1'b1; op = OP_SB; addr = 32'h0; wdata = 32'h55;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("rstwr RD strobe", {31'b0, DM_r}, 32'd1);
        @(posedge clk);
        #1;
        check("rstwr WR strobe", {31'b0, DM_w}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstwr DM_w gated",   {31'b0, DM_w},   32'd0);
        check("rstwr DM_ena gated", {31'b0, DM_ena}, 32'd0);
        check("rstwr busy gated",   {31'b0, busy},   32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("rstwr no done/busy", {31'b0, seen}, 32'd0);
        check("rstwr mem intact",   mem[0],        32'h80FE_FF7F);
        check("rstwr rdata cleared", rdata,        32'd0);
        v = '{OP_LW, 32'h0, 32'h0, 32'h80FE_FF7F, 1'b0, 2, 32'h0};
        run_vec("rstwr readback", v);

        // Reset and req on the same edge: the request is dropped.
        @(negedge clk);
        req = 1'b1; rst = 1'b1; op = OP_SW; addr = 32'h0; wdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || busy || DM_w) seen = 1'b1;
        end
        check("rstreq dropped", {31'b0, seen}, 32'd0);
        check("rstreq mem intact", mem[0], 32'h80FE_FF7F);

        // req held high: LW repeats every 3 cycles with one IDLE gap.
        @(negedge clk);
        req = 1'b1; op = OP_LW; addr = 32'h0; wdata = '0;
        n_done = 0; n_idle = 0; prev_idle = 1'b0; prev_done = 1'b0; run_bad = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (prev_done && busy) run_bad = 1'b1;
            if (!busy) begin
                n_idle++;
                if (prev_idle) run_bad = 1'b1;
            end
            if (done) begin
                n_done++;
                check($sformatf("b2b rdata %0d", n_done), rdata, 32'h80FE_FF7F);
            end
            prev_idle = !busy;
            prev_done = done;
        end
        @(negedge clk);
        req = 1'b0;
        check("b2b done count", n_done, 32'd4);
        check("b2b idle count", n_idle, 32'd4);
        check("b2b gap shape",  {31'b0, run_bad}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("never DM_r and DM_w together", {31'b0, dual_seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_master.md
DMEM_MASTER -- requirements
Module: dmem_master

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first as below.
  clk  input  1  rising-edge clock for all state
  rst  input  1  synchronous active-high reset
REQ-002 The CPU-side ports SHALL be:
  req  input  1  request pulse, sampled only in IDLE
  op  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH
  addr  input  32  byte address
  wdata  input  32  store data, right-justified for SB/SH
  busy  output  1  high whenever state != IDLE
  done  output  1  one-cycle completion pulse
  err  output  1  misalignment flag, valid with done
  rdata  output  32  extended load result, valid with done, held until the next done
REQ-003 The memory-side ports SHALL be:
  DM_ena  output  1  equals DM_r OR DM_w
  DM_r  output  1  read strobe, combinational read data
  DM_w  output  1  write strobe, committed at posedge clk
  DM_addr  output  32  word index {22'b0, addr_q[11:2]}
  DM_wdata  output  32  word to write
  DM_rdata  input  32  read word, valid in the same cycle as DM_r

Function
REQ-004 On the edge where state is IDLE and req=1, the block SHALL latch op, addr and wdata into op_q, addr_q and wd_q; req SHALL be ignored in every other state.
REQ-005 The FSM SHALL have the states IDLE, RD, WR and DONE; DONE SHALL always go to IDLE on the next edge.
REQ-006 Transitions on acceptance SHALL be: misaligned -> DONE with err=1; loads -> RD; SW -> WR; SB/SH -> RD.
REQ-007 Misaligned SHALL mean: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
REQ-008 A misaligned access SHALL NOT assert DM_r or DM_w, and SHALL leave rdata unchanged.
REQ-009 In RD, DM_r SHALL be 1 and the block SHALL capture DM_rdata into word_q at the end of the cycle.
REQ-010 From RD, loads SHALL go to DONE and SB/SH SHALL go to WR.
REQ-011 In WR, DM_w SHALL be 1; DM_wdata SHALL be wd_q for SW, and word_q with only the addressed lane(s) replaced for SB/SH.
REQ-012 Byte order SHALL be little-endian: byte k occupies bits [8k+7:8k] with k=addr_q[1:0], and a halfword occupies the lanes at addr_q[1]*16.
REQ-013 Load extraction, written to rdata on the RD->DONE edge, SHALL be: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-014 done SHALL be 1 exactly in the DONE state.
REQ-015 err SHALL be 1 in DONE only for a misaligned access, and 0 otherwise.
REQ-016 Latency from the accept edge to done high SHALL be:
  misaligned: 1 cycle
  load: 2 cycles
  SW: 2 cycles
  SB/SH: 3 cycles
REQ-017 The next req SHALL be accepted no earlier than the cycle after DONE; a req asserted during DONE SHALL be lost.
REQ-018 addr bits [31:12] SHALL be ignored: addresses wrap modulo 4 KiB.
REQ-019 DM_r and DM_w SHALL never both be 1 in the same cycle.
REQ-020 When DM_r=0, DM_rdata SHALL be ignored, so a high-Z input causes no effect.

Reset
REQ-021 When rst=1 on an edge, the block SHALL go to IDLE and clear op_q, addr_q, wd_q, word_q, rdata and err to 0.
REQ-022 DM_r, DM_w, DM_ena, busy and done SHALL be combinationally gated to 0 while rst=1, so an in-flight WR commits nothing on the reset edge.
REQ-023 Reset SHALL take priority over req in the same cycle; the request SHALL be dropped and produce no done.

Verification
REQ-024 Word store then load: SW addr=0x10, wdata=0xDEADBEEF -> DM_addr=4, DM_w for 1 cycle, done 2 cycles after accept. Then LW 0x10 -> rdata=0xDEADBEEF, err=0.
REQ-025 Byte store: memory word 4 = 0x11223344, SB addr=0x11, wdata=0xAB -> one RD cycle, then DM_wdata=0x1122AB44 in WR; done 3 cycles after accept.
REQ-026 Sign and zero extension on word 0x8000FF7F:
  LB 0x0 -> 0x0000007F
  LB 0x1 -> 0xFFFFFFFF
  LBU 0x1 -> 0x000000FF
  LH 0x2 -> 0xFFFF8000
  LHU 0x2 -> 0x00008000
REQ-027 Misalignment: LW 0x13 and SH 0x5 -> done 1 cycle after accept, err=1, DM_r=DM_w=0 throughout, rdata unchanged.
REQ-028 Reset in WR: issue SB, assert rst during the WR cycle -> no memory change at that address, state IDLE, busy=0, done never asserted.
REQ-029 Back-to-back requests: req held high continuously -> accepts occur only from IDLE, one done per accepted access, busy low for exactly 1 cycle between accesses.
